// File: rtl/sub_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
// Latency: n/a (types only).
// Backpressure: n/a.
package sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/full_sub_cell.sv
// One-bit full subtractor: d = a - b - bin, bo = borrow out.
// Latency: combinational.
// Backpressure: none.
module full_sub_cell (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bo
);

  assign d  = a ^ b ^ bin;
  assign bo = (~a & b) | (bin & ~(a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit unsigned subtractor, LSB first: {bout, diff} = a - b - bin.
// Latency: done pulses WIDTH+1 cycles after start is accepted; one op per WIDTH+2 cycles.
// Backpressure: none; start is only sampled in IDLE and ignored while busy.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sd;
  logic             br;
  logic [CW-1:0]    cnt;
  logic             d;
  logic             bo;

  full_sub_cell u_cell (
    .a   (sa[0]),
    .b   (sb[0]),
    .bin (br),
    .d   (d),
    .bo  (bo)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sd    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            cnt   <= '0;
            sd    <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          sd  <= {d, sd[WIDTH-1:1]};
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          br  <= bo;
          cnt <= cnt + 1'b1;
          // This cycle consumes the MSB, so the final word is the shift-in value.
          if (cnt == LAST) begin
            diff  <= {d, sd[WIDTH-1:1]};
            bout  <= bo;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
